// File: rtl/rr_arbiter_if.sv
// rtl/rr_arbiter_if.sv - request/grant bundle between requesters, shared resource and rr_arbiter.
interface rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] din;
  logic       ack_in;
  logic [3:0] gnt;
  logic [1:0] s;
  logic       v;
  logic       o;
  logic [3:0] ack;

  modport master (
    output req, din, ack_in,
    input  gnt, s, v, o, ack
  );

  modport slave (
    input  req, din, ack_in,
    output gnt, s, v, o, ack
  );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - 4-way round-robin arbiter with registered grant and muxed data/ack.
// Define HOLD_TIMEOUT_EN to force release after MAX_HOLD grant cycles.
module rr_arbiter #(
  parameter int MAX_HOLD = 15
) (
  input  logic          clk,
  input  logic          rst,
  rr_arbiter_if.slave   bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] pick;
  logic [1:0] idx;
  logic       found;
  logic       release_now;

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter: MAX_HOLD must be in 1..255");
  end

  // First requester at or after ptr, wrapping modulo 4.
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && bus.req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

`ifdef HOLD_TIMEOUT_EN
  logic [7:0] hold;

  // A timeout and a dropped request in the same cycle collapse into one release.
  assign release_now = !bus.req[bus.s] || (hold == 8'(MAX_HOLD));
`else
  assign release_now = !bus.req[bus.s];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bus.gnt <= 4'b0000;
      bus.s   <= 2'd0;
      bus.v   <= 1'b0;
      ptr     <= 2'd0;
`ifdef HOLD_TIMEOUT_EN
      hold    <= 8'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state   <= GRANT;
            bus.gnt <= 4'b0001 << pick;
            bus.s   <= pick;
            bus.v   <= 1'b1;
`ifdef HOLD_TIMEOUT_EN
            hold    <= 8'd1;
`endif
          end else begin
            bus.gnt <= 4'b0000;
            bus.v   <= 1'b0;
          end
        end
        GRANT: begin
          // Releasing always passes through IDLE, giving the one-cycle gap between grants.
          if (release_now) begin
            state   <= IDLE;
            bus.gnt <= 4'b0000;
            bus.v   <= 1'b0;
            ptr     <= bus.s + 2'd1;
          end else begin
`ifdef HOLD_TIMEOUT_EN
            hold    <= hold + 8'd1;
`endif
          end
        end
        default: begin
          state   <= IDLE;
          bus.gnt <= 4'b0000;
          bus.v   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o   = bus.v & bus.din[bus.s];
  assign bus.ack = bus.v ? ({3'b000, bus.ack_in} << bus.s) : 4'b0000;

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - self-checking bench for rr_arbiter: directed vectors, corner sequences, random run.
module tb_rr_arbiter;

  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst;
  rr_arbiter_if bus();

  rr_arbiter #(.MAX_HOLD(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] din;
    logic       ack_in;
    logic [3:0] gnt;
    logic [1:0] s;
    logic       v;
    logic       o;
    logic [3:0] ack;
  } vec_t;

  vec_t tbl[18];

  int ntests = 0;
  int nfail  = 0;

  // Reference model: owner is the granted requester or -1 when nobody holds the channel.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  int m_s     = 0;

  int wait_cnt[4];
  logic prev_v;

  task check(string name, logic [31:0] act, logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task model_step(logic r, logic [3:0] rq);
    bit rel;
    if (r) begin
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
      m_s     = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && rq[(m_ptr + k) % 4]) begin
          m_owner = (m_ptr + k) % 4;
          m_s     = m_owner;
          m_hold  = 1;
        end
      end
    end else begin
      rel = !rq[m_owner];
`ifdef HOLD_TIMEOUT_EN
      if (m_hold == HOLD) rel = 1'b1;
`endif
      if (rel) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
      end else begin
        m_hold++;
      end
    end
  endtask

  task step();
    @(posedge clk);
    model_step(rst, bus.req);
    #1;
  endtask

  task apply(logic r, logic [3:0] rq, logic [3:0] d, logic a);
    rst        = r;
    bus.req    = rq;
    bus.din    = d;
    bus.ack_in = a;
  endtask

  task check_model(string tag);
    logic [3:0] e_gnt;
    logic [3:0] e_ack;
    logic       e_v;
    logic       e_o;
    e_v   = (m_owner >= 0);
    e_gnt = e_v ? (4'b0001 << m_owner) : 4'b0000;
    e_o   = e_v ? bus.din[m_s] : 1'b0;
    e_ack = (e_v && bus.ack_in) ? (4'b0001 << m_s) : 4'b0000;
    check({tag, " gnt"}, 32'(bus.gnt), 32'(e_gnt));
    check({tag, " s"},   32'(bus.s),   32'(m_s));
    check({tag, " v"},   32'(bus.v),   32'(e_v));
    check({tag, " o"},   32'(bus.o),   32'(e_o));
    check({tag, " ack"}, 32'(bus.ack), 32'(e_ack));
    check({tag, " onehot"}, 32'($countones(bus.gnt) <= 1), 32'(1));
    check({tag, " v_eq_gnt"}, 32'(bus.v == (bus.gnt != 4'b0000)), 32'(1));
  endtask

  initial begin
    logic [3:0] flip;

    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000};
    tbl[1]  = '{1'b0, 4'b1010, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 4'b0000};
    tbl[2]  = '{1'b0, 4'b1000, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 4'b0000};
    tbl[3]  = '{1'b0, 4'b1000, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, 4'b0000};
    tbl[4]  = '{1'b0, 4'b0111, 4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0, 4'b0000};
    tbl[5]  = '{1'b0, 4'b0111, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 4'b0000};
    tbl[6]  = '{1'b0, 4'b0110, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000};
    tbl[7]  = '{1'b0, 4'b0100, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 4'b0000};
    tbl[8]  = '{1'b0, 4'b0100, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 4'b0100};
    tbl[9]  = '{1'b0, 4'b0100, 4'b1011, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 4'b0100};
    tbl[10] = '{1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 4'b0000};
    tbl[11] = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000};
    tbl[12] = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 4'b0001};
    tbl[13] = '{1'b0, 4'b1110, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000};
    tbl[14] = '{1'b0, 4'b1110, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 4'b0000};
    tbl[15] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 4'b0000};
    tbl[16] = '{1'b0, 4'b0000, 4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, 4'b0000};
    tbl[17] = '{1'b0, 4'b0011, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 4'b0000};

    for (int i = 0; i < 18; i++) begin
      apply(tbl[i].rst, tbl[i].req, tbl[i].din, tbl[i].ack_in);
      step();
      check($sformatf("row%0d gnt", i), 32'(bus.gnt), 32'(tbl[i].gnt));
      check($sformatf("row%0d s", i),   32'(bus.s),   32'(tbl[i].s));
      check($sformatf("row%0d v", i),   32'(bus.v),   32'(tbl[i].v));
      check($sformatf("row%0d o", i),   32'(bus.o),   32'(tbl[i].o));
      check($sformatf("row%0d ack", i), 32'(bus.ack), 32'(tbl[i].ack));
    end

    // Requester 0 holds with REQ=0011 constant.
`ifdef HOLD_TIMEOUT_EN
    for (int i = 0; i < HOLD - 1; i++) begin
      step();
      check($sformatf("hold%0d gnt", i), 32'(bus.gnt), 32'(4'b0001));
    end
    step();
    check("timeout idle gnt", 32'(bus.gnt), 32'(4'b0000));
    check("timeout idle v",   32'(bus.v),   32'(0));
    step();
    check("after timeout gnt", 32'(bus.gnt), 32'(4'b0010));
    check("after timeout s",   32'(bus.s),   32'(1));
    for (int i = 0; i < HOLD - 1; i++) step();
    apply(1'b0, 4'b0101, 4'b0000, 1'b0);
    step();
    check("coincident release gnt", 32'(bus.gnt), 32'(4'b0000));
    step();
    check("single ptr advance gnt", 32'(bus.gnt), 32'(4'b0100));
`else
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("hold%0d gnt", i), 32'(bus.gnt), 32'(4'b0001));
    end
`endif

    // Randomized run against the reference model.
    apply(1'b1, 4'b0000, 4'b0000, 1'b0);
    step();
    check_model("rand reset");
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    prev_v = 1'b0;
    rst = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(3) == 0);
      bus.req    = bus.req ^ flip;
      bus.din    = 4'($urandom);
      bus.ack_in = 1'($urandom);
      rst        = ($urandom_range(499) == 0);
      step();
      check_model($sformatf("cyc%0d", c));
      if (rst) begin
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
      end else begin
        for (int i = 0; i < 4; i++) if (!bus.req[i]) wait_cnt[i] = 0;
        if (bus.v && !prev_v) begin
          for (int i = 0; i < 4; i++) begin
            if (i == int'(bus.s)) begin
              wait_cnt[i] = 0;
            end else if (bus.req[i]) begin
              wait_cnt[i]++;
              check($sformatf("cyc%0d fair%0d", c, i), 32'(wait_cnt[i] <= 4), 32'(1));
            end
          end
        end
      end
      prev_v = bus.v;
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
